boot_sequencer: RTL and testbench

Owns the UART receive byte stream and sequences the boot of the core.
- LOAD phase: assembles incoming bytes into big-endian 32-bit words, reads a word-count header, and writes the program into instruction memory. The core is held in reset throughout.
- RUN phase: releases the core and routes all further bytes into a FIFO, drained by the core's input instruction through a valid/pop handshake.
- Sits between the UART receiver, instruction memory and the core top.

---
 rtl/boot_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_boot_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// Boot sequencer: assembles UART bytes into a header plus program words for instruction
// memory while the core is held in reset, then hands further bytes to the core via a FIFO.
module boot_sequencer #(
   parameter int INST_ADDR_W = 14,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   input  logic                   start,
   output logic                   imem_we,
   output logic [INST_ADDR_W-1:0] imem_addr,
   output logic [31:0]            imem_wdata,
   output logic                   cpu_rst,
   output logic                   load_done,
   output logic                   load_error,
   output logic                   cpu_in_valid,
   output logic [7:0]             cpu_in_data,
   input  logic                   cpu_in_pop,
   output logic                   fifo_overflow
);

   localparam int          PW         = $clog2(FIFO_DEPTH);
   localparam logic [32:0] IMEM_DEPTH = 33'd1 << INST_ADDR_W;
   localparam logic [PW:0] PTR_ONE    = {{PW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      LOAD_HDR  = 2'd0,
      LOAD_BODY = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             byte_idx_q, byte_idx_d;
   logic [23:0]            shift_q, shift_d;
   logic [31:0]            word_idx_q, word_idx_d;
   logic [31:0]            hdr_n_q, hdr_n_d;
   logic                   imem_we_q, imem_we_d;
   logic [INST_ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]            imem_wdata_q, imem_wdata_d;
   logic                   cpu_rst_q, cpu_rst_d;
   logic                   load_done_q, load_done_d;
   logic                   load_error_q, load_error_d;
   logic                   fifo_overflow_q, fifo_overflow_d;
   logic [PW:0]            wr_ptr_q, wr_ptr_d;
   logic [PW:0]            rd_ptr_q, rd_ptr_d;
   logic [7:0]             fifo_q [FIFO_DEPTH];
   logic [7:0]             fifo_d [FIFO_DEPTH];

   logic [31:0] word_s;
   logic        word_done_s;
   logic        hdr_too_big_s;
   logic        idx_in_range_s;
   logic        fifo_empty_s;
   logic        fifo_full_s;
   logic        pop_s;
   logic        push_req_s;

   // The incoming byte completes the word; start always takes precedence over rx_valid.
   assign word_s         = {shift_q, rx_data};
   assign word_done_s    = rx_valid && !start && (byte_idx_q == 2'd3) && (state_q != RUN);
   assign hdr_too_big_s  = ({1'b0, word_s} > IMEM_DEPTH);
   assign idx_in_range_s = ({1'b0, word_idx_q} < IMEM_DEPTH);
   assign fifo_empty_s   = (wr_ptr_q == rd_ptr_q);
   assign fifo_full_s    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                           (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign pop_s          = cpu_in_pop && !fifo_empty_s;
   assign push_req_s     = rx_valid && !start && (state_q == RUN);

   // Next-state, load sequencing and FIFO control.
   always_comb begin
      state_d         = state_q;
      byte_idx_d      = byte_idx_q;
      shift_d         = shift_q;
      word_idx_d      = word_idx_q;
      hdr_n_d         = hdr_n_q;
      imem_we_d       = 1'b0;
      imem_addr_d     = imem_addr_q;
      imem_wdata_d    = imem_wdata_q;
      load_done_d     = 1'b0;
      load_error_d    = load_error_q;
      fifo_overflow_d = fifo_overflow_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      fifo_d          = fifo_q;
      if (start) begin
         state_d         = LOAD_HDR;
         byte_idx_d      = 2'd0;
         shift_d         = 24'd0;
         word_idx_d      = 32'd0;
         load_error_d    = 1'b0;
         fifo_overflow_d = 1'b0;
         wr_ptr_d        = '0;
         rd_ptr_d        = '0;
      end else begin
         if (rx_valid && (state_q != RUN)) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = word_s[23:0];
         end else begin
            byte_idx_d = byte_idx_q;
         end
         case (state_q)
            LOAD_HDR: begin
               if (word_done_s) begin
                  hdr_n_d      = word_s;
                  word_idx_d   = 32'd0;
                  load_error_d = load_error_q | hdr_too_big_s;
                  if (word_s == 32'd0) begin
                     state_d     = RUN;
                     load_done_d = 1'b1;
                  end else begin
                     state_d = LOAD_BODY;
                  end
               end else begin
                  state_d = LOAD_HDR;
               end
            end
            LOAD_BODY: begin
               if (word_done_s) begin
                  // Words past the end of memory are counted but never written.
                  imem_we_d  = idx_in_range_s;
                  word_idx_d = word_idx_q + 32'd1;
                  if (idx_in_range_s) begin
                     imem_addr_d  = word_idx_q[INST_ADDR_W-1:0];
                     imem_wdata_d = word_s;
                  end else begin
                     imem_addr_d  = imem_addr_q;
                  end
                  if (word_idx_q == hdr_n_q - 32'd1) begin
                     state_d     = RUN;
                     load_done_d = 1'b1;
                  end else begin
                     state_d = LOAD_BODY;
                  end
               end else begin
                  state_d = LOAD_BODY;
               end
            end
            RUN: begin
               if (pop_s) begin
                  rd_ptr_d = rd_ptr_q + PTR_ONE;
               end else begin
                  rd_ptr_d = rd_ptr_q;
               end
               // A same-cycle pop frees the slot, so a full FIFO still accepts the byte.
               if (push_req_s && (!fifo_full_s || pop_s)) begin
                  fifo_d[wr_ptr_q[PW-1:0]] = rx_data;
                  wr_ptr_d                 = wr_ptr_q + PTR_ONE;
               end else if (push_req_s) begin
                  fifo_overflow_d = 1'b1;
               end else begin
                  fifo_overflow_d = fifo_overflow_q;
               end
            end
            default: begin
               state_d = LOAD_HDR;
            end
         endcase
      end
      cpu_rst_d = (state_d != RUN);
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q         <= LOAD_HDR;
         byte_idx_q      <= 2'd0;
         shift_q         <= 24'd0;
         word_idx_q      <= 32'd0;
         hdr_n_q         <= 32'd0;
         imem_we_q       <= 1'b0;
         imem_addr_q     <= '0;
         imem_wdata_q    <= 32'd0;
         cpu_rst_q       <= 1'b1;
         load_done_q     <= 1'b0;
         load_error_q    <= 1'b0;
         fifo_overflow_q <= 1'b0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= 8'd0;
         end
      end else begin
         state_q         <= state_d;
         byte_idx_q      <= byte_idx_d;
         shift_q         <= shift_d;
         word_idx_q      <= word_idx_d;
         hdr_n_q         <= hdr_n_d;
         imem_we_q       <= imem_we_d;
         imem_addr_q     <= imem_addr_d;
         imem_wdata_q    <= imem_wdata_d;
         cpu_rst_q       <= cpu_rst_d;
         load_done_q     <= load_done_d;
         load_error_q    <= load_error_d;
         fifo_overflow_q <= fifo_overflow_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         fifo_q          <= fifo_d;
      end
   end

   assign imem_we       = imem_we_q;
   assign imem_addr     = imem_addr_q;
   assign imem_wdata    = imem_wdata_q;
   assign cpu_rst       = cpu_rst_q;
   assign load_done     = load_done_q;
   assign load_error    = load_error_q;
   assign fifo_overflow = fifo_overflow_q;
   assign cpu_in_valid  = !fifo_empty_s;
   assign cpu_in_data   = fifo_q[rd_ptr_q[PW-1:0]];

endmodule

// File: tb/tb_boot_sequencer.sv
// Bench for boot_sequencer: directed vector table, hand-written corner sequences and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_boot_sequencer;
   localparam int AW    = 2;
   localparam int DEPTH = 16;

   logic          CLK = 1'b0;
   logic          RSTN = 1'b0;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_valid = 1'b0;
   logic          start = 1'b0;
   logic          cpu_in_pop = 1'b0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst, load_done, load_error, cpu_in_valid, fifo_overflow;
   logic [7:0]    cpu_in_data;

   int checks = 0;
   int errors = 0;
   int nwrites = 0;

   boot_sequencer #(.INST_ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RSTN(RSTN), .rx_data(rx_data), .rx_valid(rx_valid), .start(start),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_rst(cpu_rst), .load_done(load_done), .load_error(load_error),
      .cpu_in_valid(cpu_in_valid), .cpu_in_data(cpu_in_data), .cpu_in_pop(cpu_in_pop),
      .fifo_overflow(fifo_overflow)
   );

   always #5 CLK = ~CLK;

   // Reference model: phase 0 = header, 1 = body, 2 = run.
   int          m_phase;
   logic [7:0]  m_bytes [$];
   logic [7:0]  m_fifo [$];
   longint      m_n, m_widx;
   logic        m_err, m_ovf, e_we, e_rst, e_done;
   logic [31:0] e_addr, e_wdata;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_phase = 0; m_bytes.delete(); m_fifo.delete();
      m_n = 0; m_widx = 0; m_err = 1'b0; m_ovf = 1'b0;
      e_we = 1'b0; e_rst = 1'b1; e_done = 1'b0; e_addr = 32'd0; e_wdata = 32'd0;
   endfunction

   function automatic void model_step(logic v, logic [7:0] d, logic s, logic p);
      logic [31:0] w;
      bit popped;
      e_we = 1'b0; e_done = 1'b0;
      if (s) begin
         m_phase = 0; m_bytes.delete(); m_fifo.delete();
         m_widx = 0; m_err = 1'b0; m_ovf = 1'b0;
      end else if (m_phase == 2) begin
         popped = p && (m_fifo.size() != 0);
         if (popped) void'(m_fifo.pop_front());
         if (v) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
            else m_ovf = 1'b1;
         end
      end else if (v) begin
         m_bytes.push_back(d);
         if (m_bytes.size() == 4) begin
            w = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            m_bytes.delete();
            if (m_phase == 0) begin
               m_n = longint'(w); m_widx = 0;
               if (m_n > (longint'(1) << AW)) m_err = 1'b1;
               if (m_n == 0) begin m_phase = 2; e_done = 1'b1; end
               else m_phase = 1;
            end else begin
               if (m_widx < (longint'(1) << AW)) begin
                  e_we = 1'b1; e_addr = 32'(m_widx); e_wdata = w;
               end
               if (m_widx == m_n - 1) begin m_phase = 2; e_done = 1'b1; end
               m_widx++;
            end
         end
      end
      e_rst = (m_phase != 2);
   endfunction

   function automatic void compare_model();
      chk("imem_we", imem_we, e_we);
      chk("imem_addr", 32'(imem_addr), e_addr);
      chk("imem_wdata", imem_wdata, e_wdata);
      chk("cpu_rst", cpu_rst, e_rst);
      chk("load_done", load_done, e_done);
      chk("load_error", load_error, m_err);
      chk("fifo_overflow", fifo_overflow, m_ovf);
      chk("cpu_in_valid", cpu_in_valid, m_fifo.size() != 0);
      if (m_fifo.size() != 0) chk("cpu_in_data", cpu_in_data, m_fifo[0]);
      if (imem_we === 1'b1) nwrites++;
   endfunction

   task automatic cyc(input logic v, input logic [7:0] d, input logic s, input logic p);
      rx_valid = v; rx_data = d; start = s; cpu_in_pop = p;
      @(posedge CLK);
      model_step(v, d, s, p);
      #1;
      compare_model();
      rx_valid = 1'b0; start = 1'b0; cpu_in_pop = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int k = 3; k >= 0; k--) begin
         if (gaps) repeat ($urandom % 3) cyc(1'b0, 8'd0, 1'b0, 1'($urandom % 2));
         cyc(1'b1, w[k*8 +: 8], 1'b0, gaps ? 1'($urandom % 2) : 1'b0);
      end
   endtask

   typedef struct {
      logic v; logic [7:0] d; logic s; logic p;
      logic we; logic [AW-1:0] addr; logic [31:0] wdata; logic rst; logic done;
   } vec_t;

   function automatic vec_t mk(logic v, logic [7:0] d, logic s, logic we,
                               logic [AW-1:0] a, logic [31:0] wd, logic rst, logic done);
      vec_t r;
      r.v = v; r.d = d; r.s = s; r.p = 1'b0;
      r.we = we; r.addr = a; r.wdata = wd; r.rst = rst; r.done = done;
      return r;
   endfunction

   vec_t tbl [19];

   initial begin
      tbl[0]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[1]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[2]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[3]  = mk(1'b1, 8'h02, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[4]  = mk(1'b1, 8'h11, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[5]  = mk(1'b1, 8'h22, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[6]  = mk(1'b1, 8'h33, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[7]  = mk(1'b1, 8'h44, 1'b0, 1'b1, 2'd0, 32'h11223344, 1'b1, 1'b0);
      tbl[8]  = mk(1'b1, 8'hAA, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[9]  = mk(1'b1, 8'hBB, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[10] = mk(1'b1, 8'hCC, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[11] = mk(1'b1, 8'hDD, 1'b0, 1'b1, 2'd1, 32'hAABBCCDD, 1'b0, 1'b1);
      tbl[12] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
      tbl[13] = mk(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[14] = mk(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[15] = mk(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[16] = mk(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tbl[17] = mk(1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
      tbl[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);

      model_reset();
      #12;
      chk("rst_imem_we", imem_we, 1'b0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_imem_wdata", imem_wdata, 32'd0);
      chk("rst_cpu_rst", cpu_rst, 1'b1);
      chk("rst_load_done", load_done, 1'b0);
      chk("rst_load_error", load_error, 1'b0);
      chk("rst_fifo_overflow", fifo_overflow, 1'b0);
      chk("rst_cpu_in_valid", cpu_in_valid, 1'b0);
      chk("rst_cpu_in_data", cpu_in_data, 8'd0);
      @(negedge CLK);
      RSTN = 1'b1;

      // Directed table: two-word load, then a zero-length load.
      for (int i = 0; i < 19; i++) begin
         cyc(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].p);
         chk($sformatf("tbl%0d_we", i), imem_we, tbl[i].we);
         if (tbl[i].we) begin
            chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_wdata", i), imem_wdata, tbl[i].wdata);
         end
         chk($sformatf("tbl%0d_cpu_rst", i), cpu_rst, tbl[i].rst);
         chk($sformatf("tbl%0d_load_done", i), load_done, tbl[i].done);
      end

      // FIFO overflow: 17 bytes with no pops, then drain.
      for (int i = 1; i <= 17; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      chk("ovf_flag", fifo_overflow, 1'b1);
      chk("ovf_valid", cpu_in_valid, 1'b1);
      chk("ovf_head", cpu_in_data, 8'h01);
      for (int i = 1; i <= 16; i++) begin
         chk("drain_data", cpu_in_data, 8'(i));
         cyc(1'b0, 8'd0, 1'b0, 1'b1);
      end
      chk("drain_empty", cpu_in_valid, 1'b0);

      // Full FIFO with simultaneous push and pop.
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      send_word(32'd0, 1'b0);
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
      cyc(1'b1, 8'h55, 1'b0, 1'b1);
      chk("pp_no_ovf", fifo_overflow, 1'b0);
      cyc(1'b1, 8'h66, 1'b0, 1'b0);
      chk("pp_still_full", fifo_overflow, 1'b1);
      for (int j = 0; j < 16; j++) begin
         chk("pp_data", cpu_in_data, (j < 15) ? 8'h21 + 8'(j) : 8'h55);
         cyc(1'b0, 8'd0, 1'b0, 1'b1);
      end
      chk("pp_empty", cpu_in_valid, 1'b0);

      // Header larger than memory: 5 words into a 4-word memory.
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      send_word(32'd5, 1'b0);
      chk("err_set", load_error, 1'b1);
      nwrites = 0;
      for (int k = 0; k < 5; k++) send_word(32'hA000_0000 + 32'(k), 1'b0);
      chk("err_done", load_done, 1'b1);
      chk("err_cpu_rst", cpu_rst, 1'b0);
      chk("err_writes", nwrites, 4);

      // Restart mid-body, with a byte arriving alongside start.
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      send_word(32'd1, 1'b0);
      cyc(1'b1, 8'hEE, 1'b0, 1'b0);
      cyc(1'b1, 8'hEE, 1'b0, 1'b0);
      cyc(1'b1, 8'h99, 1'b1, 1'b0);
      nwrites = 0;
      send_word(32'd1, 1'b0);
      send_word(32'h12345678, 1'b0);
      chk("restart_we", imem_we, 1'b1);
      chk("restart_addr", 32'(imem_addr), 32'd0);
      chk("restart_data", imem_wdata, 32'h12345678);
      chk("restart_done", load_done, 1'b1);
      chk("restart_writes", nwrites, 1);

      // Asynchronous reset in the middle of a body word.
      cyc(1'b0, 8'd0, 1'b1, 1'b0);
      send_word(32'd2, 1'b0);
      send_word(32'hCAFEF00D, 1'b0);
      cyc(1'b1, 8'h01, 1'b0, 1'b0);
      cyc(1'b1, 8'h02, 1'b0, 1'b0);
      cyc(1'b1, 8'h03, 1'b0, 1'b0);
      #2 RSTN = 1'b0;
      #1;
      chk("arst_we", imem_we, 1'b0);
      chk("arst_addr", 32'(imem_addr), 32'd0);
      chk("arst_cpu_rst", cpu_rst, 1'b1);
      model_reset();
      @(negedge CLK);
      RSTN = 1'b1;
      nwrites = 0;
      repeat (4) cyc(1'b0, 8'd0, 1'b0, 1'b0);
      chk("arst_no_write", nwrites, 0);

      // Randomized loads and RUN traffic against the model.
      for (int it = 0; it < 40; it++) begin
         int n;
         int pv;
         cyc(1'($urandom % 2), 8'($urandom), 1'b1, 1'($urandom % 2));
         n = $urandom_range(0, 6);
         send_word(32'(n), 1'b1);
         for (int w = 0; w < n; w++) begin
            if ($urandom % 12 == 0) break;
            send_word($urandom, 1'b1);
         end
         pv = $urandom_range(1, 3);
         for (int c = 0; c < 30; c++)
            cyc(1'(($urandom % 4) < pv), 8'($urandom), 1'b0, 1'(($urandom % 4) >= pv));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
